input_ctrl_buf: RTL

- Clocked, parametrised successor of the router input controller: one input port of a mesh NoC router.
- Buffers incoming packets in a DEPTH-entry FIFO.
- Makes the dimension-ordered (X then Y) routing decision and decrements the hop field it consumes.
- Presents the packet to exactly one of five output channels (N, S, E, W, PE) over valid/ready handshakes.
- One instance per router input port; feeds the router's output arbiters.

---
 rtl/noc_pkg.sv | 67 ++++++
 rtl/sync_fifo.sv | 57 +++++
 rtl/input_ctrl_buf.sv | 138 +++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared NoC router types: channel indices, default packet field positions
// and the dimension-ordered (X then Y) routing helper.
package noc_pkg;

  localparam int NUM_DIR = 5;

  typedef enum logic [2:0] {
    DIR_N  = 3'd0,
    DIR_S  = 3'd1,
    DIR_E  = 3'd2,
    DIR_W  = 3'd3,
    DIR_PE = 3'd4
  } dir_e;

  localparam int PKT_W_DEF     = 57;
  localparam int HOP_W_DEF     = 3;
  localparam int X_DIR_BIT_DEF = 47;
  localparam int X_HOP_LSB_DEF = 44;
  localparam int Y_DIR_BIT_DEF = 43;
  localparam int Y_HOP_LSB_DEF = 40;

  // Widest packet the routing helper handles; callers zero-extend into it.
  localparam int MAX_PKT_W = 128;

  typedef logic [MAX_PKT_W-1:0] pkt_max_t;

  typedef struct packed {
    dir_e     sel;
    pkt_max_t pkt;
  } route_t;

  // Subtracting one at the hop field's LSB never borrows out of the field
  // because it is only applied when that field is nonzero.
  function automatic route_t route_xy(input pkt_max_t pkt,
                                      input int       x_dir_bit,
                                      input int       x_hop_lsb,
                                      input int       y_dir_bit,
                                      input int       y_hop_lsb,
                                      input int       hop_w);
    pkt_max_t hop_mask;
    pkt_max_t x_hop;
    pkt_max_t y_hop;
    pkt_max_t x_dir;
    pkt_max_t y_dir;
    route_t   r;
    hop_mask = (pkt_max_t'(1) << hop_w) - pkt_max_t'(1);
    x_hop    = (pkt >> x_hop_lsb) & hop_mask;
    y_hop    = (pkt >> y_hop_lsb) & hop_mask;
    x_dir    = (pkt >> x_dir_bit) & pkt_max_t'(1);
    y_dir    = (pkt >> y_dir_bit) & pkt_max_t'(1);
    r.sel    = DIR_PE;
    r.pkt    = pkt;
    if (x_hop != '0) begin
      r.sel = (x_dir != '0) ? DIR_E : DIR_W;
      r.pkt = pkt - (pkt_max_t'(1) << x_hop_lsb);
    end else if (y_hop != '0) begin
      r.sel = (y_dir != '0) ? DIR_N : DIR_S;
      r.pkt = pkt - (pkt_max_t'(1) << y_hop_lsb);
    end
    return r;
  endfunction

  function automatic logic [NUM_DIR-1:0] dir_onehot(input dir_e d);
    return NUM_DIR'(1) << d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-high reset; DEPTH need not be a
// power of two. Push is refused when full even if a pop happens the same cycle.
module sync_fifo #(
  parameter int PKT_W = 57,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [PKT_W-1:0]           wdata,
  output logic [PKT_W-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PKT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/input_ctrl_buf.sv
// Mesh router input port: FIFO, XY routing with hop decrement, one-hot
// valid/ready output stage. INPUT_CTRL_BUF_STATS_EN adds per-channel counters.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | output register empty, out_valid=0
//   ST_HOLD | routed packet held, one-hot out_valid until its channel fires
module input_ctrl_buf
  import noc_pkg::*;
#(
  parameter int PKT_W     = PKT_W_DEF,
  parameter int DEPTH     = 4,
  parameter int HOP_W     = HOP_W_DEF,
  parameter int X_DIR_BIT = X_DIR_BIT_DEF,
  parameter int X_HOP_LSB = X_HOP_LSB_DEF,
  parameter int Y_DIR_BIT = Y_DIR_BIT_DEF,
  parameter int Y_HOP_LSB = Y_HOP_LSB_DEF
`ifdef INPUT_CTRL_BUF_STATS_EN
  , parameter int CNT_W   = 16
`endif
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PKT_W-1:0]           in_data,
  output logic [NUM_DIR-1:0]         out_valid,
  input  logic [NUM_DIR-1:0]         out_ready,
  output logic [PKT_W-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef INPUT_CTRL_BUF_STATS_EN
  , output logic [NUM_DIR*CNT_W-1:0] pkt_cnt
`endif
);

  typedef enum logic {ST_IDLE, ST_HOLD} state_e;

  state_e             state_q, state_d;
  logic [NUM_DIR-1:0] vld_q, vld_d;
  logic [PKT_W-1:0]   data_q, data_d;
  logic [PKT_W-1:0]   head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               load;
  logic               fire;
  route_t             route;
  logic               unused_route_hi;

  assign in_ready = !fifo_full && !reset;
  assign push     = in_valid && in_ready;

  sync_fifo #(
    .PKT_W (PKT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (load),
    .wdata (in_data),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (occupancy)
  );

  always_comb begin
    route = route_xy(pkt_max_t'(head), X_DIR_BIT, X_HOP_LSB,
                     Y_DIR_BIT, Y_HOP_LSB, HOP_W);
  end

  // Bits above PKT_W are always zero after the zero-extension.
  assign unused_route_hi = ^route.pkt[MAX_PKT_W-1:PKT_W];

  // Only the selected channel's ready can complete a transfer.
  assign fire = |(vld_q & out_ready);

  always_comb begin
    state_d = state_q;
    vld_d   = vld_q;
    data_d  = data_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          load    = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (fire) begin
          if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_d = ST_IDLE;
            vld_d   = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load) begin
      vld_d  = dir_onehot(route.sel);
      data_d = route.pkt[PKT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      vld_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = vld_q;
  assign out_data  = data_q;

`ifdef INPUT_CTRL_BUF_STATS_EN
  for (genvar i = 0; i < NUM_DIR; i++) begin : g_stat
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= '0;
      end else if (vld_q[i] && out_ready[i] && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
    assign pkt_cnt[i*CNT_W +: CNT_W] = cnt_q;
  end
`endif

endmodule
